// File: rtl/asyc_fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversion helpers.
// Used by the write-side controller, the read-side controller and the RAM wrapper.
package asyc_fifo_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 32;

    // Converters work on a 32-bit container. Callers zero-extend narrower pointers,
    // which leaves the low bits of the result correct for any width up to 32.
    localparam int GRAY_MAX_W = 32;
    typedef logic [GRAY_MAX_W-1:0] gvec_t;

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/asyc_fifo_wr_ctrl_if.sv
// Write-side handshake bundle between producer and write controller.
// The write_almost_full signal exists only when ASYC_FIFO_WR_ALMOST_FULL_EN is defined.
interface asyc_fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = asyc_fifo_pkg::ADDR_WIDTH
);
    logic                  write_ena;
    logic [ADDR_WIDTH:0]   read_ptr_gray;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [ADDR_WIDTH:0]   write_ptr_gray;
    logic                  write_full;
    logic [ADDR_WIDTH:0]   write_level;
    logic                  write_overflow;
`ifdef ASYC_FIFO_WR_ALMOST_FULL_EN
    logic                  write_almost_full;
`endif

    // master: producer side; slave: the write controller
    modport master (
        output write_ena,
        output read_ptr_gray,
        input  write_addr,
        input  write_ptr_gray,
        input  write_full,
        input  write_level,
`ifdef ASYC_FIFO_WR_ALMOST_FULL_EN
        input  write_almost_full,
`endif
        input  write_overflow
    );

    modport slave (
        input  write_ena,
        input  read_ptr_gray,
        output write_addr,
        output write_ptr_gray,
        output write_full,
        output write_level,
`ifdef ASYC_FIFO_WR_ALMOST_FULL_EN
        output write_almost_full,
`endif
        output write_overflow
    );

endinterface

// File: rtl/asyc_fifo_sync2.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
module asyc_fifo_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/asyc_fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointers, full flag, level, overflow.
// Optional almost-full output enabled by defining ASYC_FIFO_WR_ALMOST_FULL_EN.
module asyc_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = asyc_fifo_pkg::ADDR_WIDTH
`ifdef ASYC_FIFO_WR_ALMOST_FULL_EN
  , parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
`endif
) (
    input  logic               write_clk,
    input  logic               write_rst_n,
    asyc_fifo_wr_ctrl_if.slave wif
);
    import asyc_fifo_pkg::*;

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int MSB   = PTR_W - 1;

    // The full pattern inverts the top two Gray bits, so two address bits are needed.
    if (ADDR_WIDTH < 2 || PTR_W > GRAY_MAX_W) begin : g_bad_width
        $error("asyc_fifo_wr_ctrl: ADDR_WIDTH out of range");
    end

    logic [MSB:0] wbin_q,  wbin_d;
    logic [MSB:0] wgray_q, wgray_d;
    logic         full_q,  full_d;
    logic [MSB:0] level_q, level_d;
    logic         ovf_q,   ovf_d;
    logic [MSB:0] rq2;
    logic [MSB:0] rbin_sync;
    logic [MSB:0] full_pat;
    logic         push;

    asyc_fifo_sync2 #(
        .WIDTH (PTR_W)
    ) u_rptr_sync (
        .clk_i   (write_clk),
        .rst_n_i (write_rst_n),
        .d_i     (wif.read_ptr_gray),
        .q_o     (rq2)
    );

    always_comb begin
        push      = wif.write_ena & ~full_q;
        wbin_d    = wbin_q + PTR_W'(push);
        wgray_d   = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));
        rbin_sync = PTR_W'(gray2bin(GRAY_MAX_W'(rq2)));
        full_pat  = {~rq2[MSB:MSB-1], rq2[MSB-2:0]};
        full_d    = (wgray_d == full_pat);
        // Read side is seen late through the synchroniser, so this never under-reports.
        level_d   = wbin_d - rbin_sync;
        ovf_d     = ovf_q | (wif.write_ena & full_q);
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ASYC_FIFO_WR_ALMOST_FULL_EN
    logic afull_q, afull_d;

    assign afull_d = (level_d >= PTR_W'(AFULL_THRESH));

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign wif.write_almost_full = afull_q;
`endif

    // Address comes straight from the pointer register so the RAM writes on the advancing edge.
    assign wif.write_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wif.write_ptr_gray = wgray_q;
    assign wif.write_full     = full_q;
    assign wif.write_level    = level_q;
    assign wif.write_overflow = ovf_q;

endmodule
